// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - run control, config and shift-history matcher for the serial pattern detector
// A run arms on start, counts matches of the held pattern, and stops in DONE once the target count is hit.
module seq_det_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             in_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [PAT_W-1:0] PAT_RST  = (PAT_W == 4) ? PAT_W'(4'b1101) : {PAT_W{1'b1}};
  localparam logic [FW-1:0]    FILL_MIN = FW'(PAT_W - 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [PAT_W-2:0]   hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_d, in_ready_d, busy_d, done_d;

  logic [PAT_W-1:0]   window;
  logic [CNT_W-1:0]   cnt_inc;
  logic [FW-1:0]      fill_inc;
  logic               accept;
  logic               hit;

  // The window is the new bit appended to the retained history; only full windows count.
  assign window   = {hist_q, in};
  assign accept   = (state_q == S_ARMED) && in_valid && in_ready && !abort;
  assign hit      = accept && (fill_q >= FILL_MIN) && (window == pattern_q);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pattern_q <= PAT_RST;
      overlap_q <= 1'b1;
      target_q  <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      match     <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      match     <= match_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          overlap_d = cfg_overlap;
          target_d  = cfg_target;
        end
        if (start && !abort) begin
          state_d = S_ARMED;
          cnt_d   = '0;
          hist_d  = '0;
          fill_d  = '0;
        end
      end
      S_ARMED: begin
        if (abort) begin
          state_d = S_IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end else if (accept) begin
          if (hit) begin
            cnt_d = cnt_inc;
            if (target_q != '0 && cnt_inc == target_q) begin
              state_d = S_DONE;
            end
          end
          // Non-overlap mode restarts the window from scratch after every match.
          if (hit && !overlap_q) begin
            hist_d = '0;
            fill_d = '0;
          end else begin
            hist_d = window[PAT_W-2:0];
            fill_d = fill_inc;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end else if (start) begin
          state_d = S_ARMED;
          cnt_d   = '0;
          hist_d  = '0;
          fill_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    match_d    = hit;
    in_ready_d = (state_d == S_ARMED);
    busy_d     = (state_d == S_ARMED);
    done_d     = (state_d == S_DONE);
  end

  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - scoreboard bench for seq_det_ctrl
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_we, cfg_overlap, start, abort, in_valid, in;
  logic [3:0] cfg_pattern;
  logic [7:0] cfg_target;
  logic       in_ready, match, busy, done;
  logic [7:0] match_cnt;

  int vectors = 0;
  int miscompares = 0;

  bit [3:0] m_pat;
  bit       m_ovl;
  bit [7:0] m_tgt, m_cnt;
  int       m_state;
  bit       m_bits[$];
  bit       exp_q[$];

  seq_det_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start),
    .abort(abort), .in_valid(in_valid), .in(in), .in_ready(in_ready),
    .match(match), .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pat = 4'b1101; m_ovl = 1'b1; m_tgt = 8'd0; m_cnt = 8'd0; m_state = 0;
    m_bits.delete();
  endtask

  // Model keeps the accepted bits of the current window and decides the expected match.
  task automatic send_bit(input bit v, input bit b);
    bit e;
    e = 1'b0;
    in_valid = v; in = b;
    if (v && m_state == 1) begin
      m_bits.push_back(b);
      if (m_bits.size() > 4) void'(m_bits.pop_front());
      if (m_bits.size() == 4 && m_bits[0] == m_pat[3] && m_bits[1] == m_pat[2] &&
          m_bits[2] == m_pat[1] && m_bits[3] == m_pat[0]) begin
        e = 1'b1;
        if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
        if (!m_ovl) m_bits.delete();
        if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
      end
    end
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    if (m_state != 1) begin m_state = 1; m_cnt = 8'd0; m_bits.delete(); end
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    if (m_state != 0) begin m_state = 0; m_bits.delete(); end
    step();
    abort = 1'b0;
  endtask

  task automatic cfg_write(input bit [3:0] p, input bit o, input bit [7:0] t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_overlap = o; cfg_target = t;
    if (m_state == 0) begin m_pat = p; m_ovl = o; m_tgt = t; end
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cfg_we = 0; cfg_pattern = 0; cfg_overlap = 0; cfg_target = 0;
    start = 0; abort = 0; in_valid = 0; in = 0;
    step(); step();
    rst = 1'b1;
    model_reset();
    vectors++;
    if ({in_ready, match, busy, done} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {in_ready, match, busy, done});
    end
    vectors++;
    if (match_cnt !== 8'd0) begin
      miscompares++; $display("FAIL reset_cnt: got %0d want 0", match_cnt);
    end
  endtask

  task automatic test_overlap();
    bit seq[7] = '{1, 1, 0, 1, 1, 0, 1};
    bit e;
    do_start();
    vectors++;
    if ({busy, in_ready} !== 2'b11) begin
      miscompares++; $display("FAIL ovl_armed: got %b want 11", {busy, in_ready});
    end
    for (int i = 0; i < 7; i++) begin
      send_bit(1'b1, seq[i]);
      e = exp_q.pop_front();
      vectors++;
      if (match !== e) begin
        miscompares++; $display("FAIL ovl_match bit%0d: got %b want %b", i + 1, match, e);
      end
    end
    vectors++;
    if (match_cnt !== 8'd2 || busy !== 1'b1) begin
      miscompares++; $display("FAIL ovl_cnt: got cnt=%0d busy=%b want cnt=2 busy=1", match_cnt, busy);
    end
  endtask

  task automatic test_nonoverlap();
    bit seq[11] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1};
    bit e;
    do_abort();
    cfg_write(4'b1101, 1'b0, 8'd0);
    do_start();
    for (int i = 0; i < 11; i++) begin
      send_bit(1'b1, seq[i]);
      e = exp_q.pop_front();
      vectors++;
      if (match !== e) begin
        miscompares++; $display("FAIL novl_match bit%0d: got %b want %b", i + 1, match, e);
      end
    end
    vectors++;
    if (match_cnt !== 8'd2) begin
      miscompares++; $display("FAIL novl_cnt: got %0d want 2", match_cnt);
    end
  endtask

  task automatic test_target();
    bit pat[4] = '{1, 1, 0, 1};
    bit e;
    do_abort();
    cfg_write(4'b1101, 1'b0, 8'd3);
    do_start();
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1, pat[i % 4]);
      e = exp_q.pop_front();
      vectors++;
      if (match !== e) begin
        miscompares++; $display("FAIL tgt_match bit%0d: got %b want %b", i + 1, match, e);
      end
      if (i == 11) begin
        vectors++;
        if ({match, done, in_ready} !== 3'b110) begin
          miscompares++; $display("FAIL tgt_done_edge: got %b want 110", {match, done, in_ready});
        end
      end
    end
    vectors++;
    if (match_cnt !== 8'd3 || done !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL tgt_hold: got cnt=%0d done=%b busy=%b want 3 1 0", match_cnt, done, busy);
    end
    do_start();
    vectors++;
    if (match_cnt !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL tgt_restart: got cnt=%0d busy=%b done=%b want 0 1 0", match_cnt, busy, done);
    end
  endtask

  task automatic test_bubbles();
    bit pat[4] = '{1, 1, 0, 1};
    bit e;
    int seen;
    seen = 0;
    do_abort();
    cfg_write(4'b1101, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 0) send_bit(1'b1, pat[i]);
        else        send_bit(1'b0, 1'($urandom_range(0, 1)));
        e = exp_q.pop_front();
        if (match === 1'b1) seen++;
        vectors++;
        if (match !== e) begin
          miscompares++; $display("FAIL bubble_match bit%0d slot%0d: got %b want %b", i + 1, j, match, e);
        end
      end
    end
    vectors++;
    if (seen != 1) begin
      miscompares++; $display("FAIL bubble_count: got %0d want 1", seen);
    end
  endtask

  task automatic test_abort_seq();
    bit seq1[3] = '{1, 1, 0};
    bit seq2[4] = '{1, 1, 0, 1};
    bit e;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, seq1[i]);
      e = exp_q.pop_front();
    end
    do_abort();
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || match_cnt !== 8'd1) begin
      miscompares++; $display("FAIL abort_idle: got busy=%b rdy=%b cnt=%0d want 0 0 1", busy, in_ready, match_cnt);
    end
    do_start();
    send_bit(1'b1, 1'b1);
    e = exp_q.pop_front();
    vectors++;
    if (match !== e || match !== 1'b0) begin
      miscompares++; $display("FAIL abort_stale: got %b want 0", match);
    end
    cfg_write(4'b1010, 1'b1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, seq2[i]);
      e = exp_q.pop_front();
      vectors++;
      if (match !== e) begin
        miscompares++; $display("FAIL cfg_ignored bit%0d: got %b want %b", i + 1, match, e);
      end
    end
    vectors++;
    if (match_cnt !== 8'd1) begin
      miscompares++; $display("FAIL cfg_ignored_cnt: got %0d want 1", match_cnt);
    end
    do_abort();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    vectors++;
    if ({busy, done, in_ready} !== 3'b000) begin
      miscompares++; $display("FAIL start_abort: got %b want 000", {busy, done, in_ready});
    end
    do_start();
    start = 1'b1; abort = 1'b1;
    if (m_state != 0) begin m_state = 0; m_bits.delete(); end
    step();
    start = 1'b0; abort = 1'b0;
    vectors++;
    if ({busy, done, in_ready} !== 3'b000) begin
      miscompares++; $display("FAIL start_abort_armed: got %b want 000", {busy, done, in_ready});
    end
  endtask

  task automatic test_reset_midrun();
    bit seq1[3] = '{0, 1, 1};
    bit seq2[11] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    bit e;
    cfg_write(4'b0110, 1'b1, 8'd2);
    do_start();
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, seq1[i]);
      e = exp_q.pop_front();
    end
    rst = 1'b0; in_valid = 1'b1; in = 1'b0;
    step();
    rst = 1'b1; in_valid = 1'b0;
    model_reset();
    vectors++;
    if ({in_ready, match, busy, done} !== 4'b0000 || match_cnt !== 8'd0) begin
      miscompares++; $display("FAIL midrun_reset: got flags=%b cnt=%0d want 0000 0",
                              {in_ready, match, busy, done}, match_cnt);
    end
    do_start();
    for (int i = 0; i < 11; i++) begin
      send_bit(1'b1, seq2[i]);
      e = exp_q.pop_front();
      vectors++;
      if (match !== e) begin
        miscompares++; $display("FAIL midrun_match bit%0d: got %b want %b", i + 1, match, e);
      end
      if (i == 3) begin
        vectors++;
        if (match !== 1'b0) begin
          miscompares++; $display("FAIL midrun_old_pattern: got %b want 0", match);
        end
      end
    end
    vectors++;
    if (match_cnt !== m_cnt || busy !== 1'b1) begin
      miscompares++; $display("FAIL midrun_cnt: got cnt=%0d busy=%b want %0d 1", match_cnt, busy, m_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_target();
    test_bubbles();
    test_abort_seq();
    test_reset_midrun();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
